enable_signals_organizer: RTL and testbench
===========================================

// Module: enable_signals_organizer
// PURPOSE
//  Front-end conditioner for the FIFO. Takes asynchronous level requests, e.g. from buttons or switches.
//  Each request passes through a multi-flop synchronizer and then a rising-edge detector.
//  Every asserted level becomes exactly one clk-wide read/write strobe.
//  The write data word is synchronized too and is captured together with the write strobe.
// PARAMETERS
//  BIT_DEPTH    8  width of the data word, value_to_write / synchr_to_write
//  SYNC_STAGES  2  synchronizer flops per input, legal range 2..4
// PORTS
//  clk                 in   1          single system clock; all logic on its rising edge
//  rst                 in   1          synchronous reset, active-low: rst==0 at a rising clk edge resets
//  enable_read         in   1          async level read request
//  enable_write        in   1          async level write request
//  value_to_write      in   BIT_DEPTH  async data word to be written
//  synchr_enable_read  out  1          one-cycle read strobe
//  synchr_enable_write out  1          one-cycle write strobe
//  synchr_to_write     out  BIT_DEPTH  data word paired with the write strobe
// BEHAVIOUR
//  Reset (rst==0 at an edge):
//   - all synchronizer flops, edge-history flops and outputs go to 0;
//   - takes priority over everything else.
//  Synchronizer, per enable input and per data bit:
//   - a SYNC_STAGES-deep flop chain; s[0]<=in, s[i]<=s[i-1].
//  Edge detect, per enable, with prev<=s[last]:
//   - strobe <= s[last] & ~prev (registered output);
//   - strobe is never combinational from an input.
//  Latency:
//   - input first sampled high at edge k -> strobe high from edge k+SYNC_STAGES for exactly 1 cycle;
//   - with default SYNC_STAGES=2 the strobe rises at edge k+2 and falls at edge k+3.
//  Level held high for any time:
//   - exactly one strobe is produced;
//   - the input must go low, and be sampled low, before another strobe can occur.
//  Short pulses:
//   - a high level sampled by at least one edge gives exactly one strobe;
//   - a glitch between edges may be missed; this is acceptable.
//  Write data:
//   - on the edge where synchr_enable_write goes 1, synchr_to_write <= data s[last];
//   - the data stays unchanged until the next write strobe or reset;
//   - the data must be stable SYNC_STAGES cycles before enable_write rises.
//  Read and write paths are independent:
//   - simultaneous requests give simultaneous strobes in the same cycle;
//   - there is no arbitration; the FIFO handles concurrent read and write.
//  Reset mid-operation:
//   - history is cleared;
//   - an input still high after rst returns to 1 gives one fresh strobe SYNC_STAGES cycles later.
//  No overflow or underflow logic here; full and empty are the FIFO's job.
// TESTING  (clk period 2 ns, defaults)
//  1. Reset:
//     - drive rst=0 for 1 cycle with enables=1;
//     - all outputs are 0 during reset;
//     - strobes appear 2 cycles after rst=1.
//  2. Single write:
//     - value_to_write=7, enable_write held high 5 cycles;
//     - synchr_enable_write is high for exactly 1 cycle, 2 cycles after the first sampling edge;
//     - synchr_to_write==7 from that edge onward.
//  3. Overlapped requests:
//     - enable_write high, then enable_read high 2 cycles later, both dropped together;
//     - one write strobe and one read strobe occur, 2 cycles apart.
//  4. Simultaneous requests:
//     - both enables rise at the same edge;
//     - both strobes are high in the same single cycle.
//  5. Re-trigger:
//     - drop enable_write for 1 cycle, then raise it again with value_to_write=8'hA5;
//     - a second write strobe occurs;
//     - synchr_to_write changes 7 -> 8'hA5 exactly at that strobe.
//  6. Hold:
//     - enable_read held high 20 cycles;
//     - exactly 1 read strobe and 0 write strobes occur.

Source files
------------

// File: rtl/enable_signals_organizer.sv
// Conditions asynchronous read/write level requests into single-cycle strobes,
// with the write data word synchronized and captured alongside the write strobe.
module enable_signals_organizer #(
    parameter int BIT_DEPTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_read,
    input  logic                 enable_write,
    input  logic [BIT_DEPTH-1:0] value_to_write,
    output logic                 synchr_enable_read,
    output logic                 synchr_enable_write,
    output logic [BIT_DEPTH-1:0] synchr_to_write
);

    localparam int LAST = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0]                rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0]                wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0][BIT_DEPTH-1:0] data_sync_q, data_sync_d;
    logic                                  rd_prev_q, rd_prev_d;
    logic                                  wr_prev_q, wr_prev_d;
    logic                                  rd_strobe_q, rd_strobe_d;
    logic                                  wr_strobe_q, wr_strobe_d;
    logic [BIT_DEPTH-1:0]                  wr_data_q, wr_data_d;

    always_comb begin
        rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], enable_read};
        wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], enable_write};
        data_sync_d = data_sync_q;
        data_sync_d[0] = value_to_write;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync_d[i] = data_sync_q[i-1];
        end

        rd_prev_d   = rd_sync_q[LAST];
        wr_prev_d   = wr_sync_q[LAST];
        rd_strobe_d = rd_sync_q[LAST] & ~rd_prev_q;
        wr_strobe_d = wr_sync_q[LAST] & ~wr_prev_q;

        // The data word travels through its own chain, so it lines up with the
        // enable sample that produced this strobe.
        wr_data_d = wr_strobe_d ? data_sync_q[LAST] : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_sync_q   <= '0;
            wr_sync_q   <= '0;
            data_sync_q <= '0;
            rd_prev_q   <= 1'b0;
            wr_prev_q   <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            rd_sync_q   <= rd_sync_d;
            wr_sync_q   <= wr_sync_d;
            data_sync_q <= data_sync_d;
            rd_prev_q   <= rd_prev_d;
            wr_prev_q   <= wr_prev_d;
            rd_strobe_q <= rd_strobe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign synchr_enable_read  = rd_strobe_q;
    assign synchr_enable_write = wr_strobe_q;
    assign synchr_to_write     = wr_data_q;

endmodule

// File: tb/tb_enable_signals_organizer.sv
// Directed and randomized checks of the request conditioner against an
// edge-indexed history model of the sampled inputs.
module tb_enable_signals_organizer;

    localparam int BIT_DEPTH   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int MAXN        = 4096;

    logic                 clk;
    logic                 rst;
    logic                 enable_read;
    logic                 enable_write;
    logic [BIT_DEPTH-1:0] value_to_write;
    logic                 synchr_enable_read;
    logic                 synchr_enable_write;
    logic [BIT_DEPTH-1:0] synchr_to_write;

    enable_signals_organizer #(
        .BIT_DEPTH  (BIT_DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_read        (enable_read),
        .enable_write       (enable_write),
        .value_to_write     (value_to_write),
        .synchr_enable_read (synchr_enable_read),
        .synchr_enable_write(synchr_enable_write),
        .synchr_to_write    (synchr_to_write)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Input values as seen at each clock edge, indexed by edge number.
    bit                   rd_h [MAXN];
    bit                   wr_h [MAXN];
    logic [BIT_DEPTH-1:0] d_h  [MAXN];
    int                   n        = 0;
    int                   last_rst = -1;

    logic                 exp_rd, exp_wr;
    logic [BIT_DEPTH-1:0] exp_data;
    int                   checks = 0;
    int                   errors = 0;
    int                   rd_cnt = 0;
    int                   wr_cnt = 0;

    // A sample taken at or before the latest reset edge counts as low.
    function automatic bit eff_rd(input int j);
        return (j >= 0 && j > last_rst) ? rd_h[j] : 1'b0;
    endfunction

    function automatic bit eff_wr(input int j);
        return (j >= 0 && j > last_rst) ? wr_h[j] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit wr, input logic [BIT_DEPTH-1:0] v);
        rst            = r;
        enable_read    = rd;
        enable_write   = wr;
        value_to_write = v;
        @(posedge clk);
        #1;
        rd_h[n] = rd;
        wr_h[n] = wr;
        d_h[n]  = v;
        if (!r) begin
            last_rst = n;
            exp_rd   = 1'b0;
            exp_wr   = 1'b0;
            exp_data = '0;
        end else begin
            // Strobe after edge n: high sample at n-SYNC_STAGES, low one edge earlier.
            exp_rd = eff_rd(n - SYNC_STAGES) && !eff_rd(n - SYNC_STAGES - 1);
            exp_wr = eff_wr(n - SYNC_STAGES) && !eff_wr(n - SYNC_STAGES - 1);
            if (exp_wr) exp_data = d_h[n - SYNC_STAGES];
        end
        chk("rd_strobe", {31'd0, synchr_enable_read}, {31'd0, exp_rd});
        chk("wr_strobe", {31'd0, synchr_enable_write}, {31'd0, exp_wr});
        chk("wr_data", {24'd0, synchr_to_write}, {24'd0, exp_data});
        rd_cnt += int'(synchr_enable_read);
        wr_cnt += int'(synchr_enable_write);
        n++;
    endtask

    initial begin
        bit                   rd_l, wr_l, rst_l;
        logic [BIT_DEPTH-1:0] v_l;

        // Reset with both enables high, then release: strobes two edges later.
        cyc(0, 0, 0, 8'h00);
        cyc(0, 1, 1, 8'h3C);
        rd_cnt = 0; wr_cnt = 0;
        repeat (4) cyc(1, 1, 1, 8'h3C);
        repeat (3) cyc(1, 0, 0, 8'h3C);
        chk("post_reset_rd_count", rd_cnt, 1);
        chk("post_reset_wr_count", wr_cnt, 1);

        // Single write of 7 held for five cycles.
        rd_cnt = 0; wr_cnt = 0;
        repeat (3) cyc(1, 0, 0, 8'd7);
        repeat (5) cyc(1, 0, 1, 8'd7);
        repeat (3) cyc(1, 0, 0, 8'd7);
        chk("single_write_count", wr_cnt, 1);
        chk("single_write_data", {24'd0, synchr_to_write}, 32'd7);

        // Overlapped: write first, read two cycles later, dropped together.
        rd_cnt = 0; wr_cnt = 0;
        repeat (2) cyc(1, 0, 1, 8'd7);
        repeat (3) cyc(1, 1, 1, 8'd7);
        repeat (4) cyc(1, 0, 0, 8'd7);
        chk("overlap_rd_count", rd_cnt, 1);
        chk("overlap_wr_count", wr_cnt, 1);

        // Simultaneous rise of both requests.
        rd_cnt = 0; wr_cnt = 0;
        repeat (3) cyc(1, 1, 1, 8'd7);
        repeat (3) cyc(1, 0, 0, 8'd7);
        chk("simul_rd_count", rd_cnt, 1);
        chk("simul_wr_count", wr_cnt, 1);

        // Re-trigger after a one-cycle drop, with a new data word.
        rd_cnt = 0; wr_cnt = 0;
        repeat (3) cyc(1, 0, 1, 8'd7);
        cyc(1, 0, 0, 8'hA5);
        repeat (4) cyc(1, 0, 1, 8'hA5);
        repeat (3) cyc(1, 0, 0, 8'hA5);
        chk("retrigger_wr_count", wr_cnt, 2);
        chk("retrigger_data", {24'd0, synchr_to_write}, 32'hA5);

        // Read held for twenty cycles.
        rd_cnt = 0; wr_cnt = 0;
        repeat (20) cyc(1, 1, 0, 8'h11);
        repeat (3) cyc(1, 0, 0, 8'h11);
        chk("hold_rd_count", rd_cnt, 1);
        chk("hold_wr_count", wr_cnt, 0);

        // Random levels, data and occasional resets.
        rd_l = 1'b0; wr_l = 1'b0; v_l = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rd_l = ~rd_l;
            if ($urandom_range(0, 3) == 0) wr_l = ~wr_l;
            if ($urandom_range(0, 2) == 0) v_l = BIT_DEPTH'($urandom);
            rst_l = ($urandom_range(0, 59) != 0);
            cyc(rst_l, rd_l, wr_l, v_l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
